// File: rtl/ha_pkg.sv
// Shared constants and types for the half-adder family.
// Latency: n/a (types only). Backpressure: n/a.
package ha_pkg;

    localparam int HA_MAX_WIDTH = 64;

    // One lane's result, packed as {carry, sum}.
    typedef struct packed {
        logic carry;
        logic sum;
    } ha_lane_t;

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit combinational half adder: sum = a ^ b, carry = a & b.
// Latency: 0 cycles. Backpressure: none.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH-lane half adder with optional output register and valid tracking.
// Latency: 1 cycle (REG_OUT=1) or 0 (REG_OUT=0). Backpressure: none, accepts every cycle.
module half_adder
    import ha_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_bad_width
        $error("half_adder: WIDTH must be in 1..%0d", HA_MAX_WIDTH);
    end

    ha_lane_t [WIDTH-1:0] lane;
    logic     [WIDTH-1:0] sum_c;
    logic     [WIDTH-1:0] carry_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (lane[i].sum),
            .carry (lane[i].carry)
        );
    end

    always_comb begin
        sum_c   = '0;
        carry_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_c[i]   = lane[i].sum;
            carry_c[i] = lane[i].carry;
        end
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] carry_q;
        logic             valid_q;

        // Data holds when no input is accepted; only valid drops.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= '0;
                valid_q <= 1'b0;
            end else begin
                if (in_valid) begin
                    sum_q   <= sum_c;
                    carry_q <= carry_c;
                end
                valid_q <= in_valid;
            end
        end

        assign sum       = sum_q;
        assign carry     = carry_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        logic rst_flag;

        always_ff @(posedge clk) begin
            rst_flag <= ~rst_n;
        end

        assign sum       = rst_flag ? '0 : sum_c;
        assign carry     = rst_flag ? '0 : carry_c;
        assign out_valid = rst_flag ? 1'b0 : in_valid;
    end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: four configurations checked against a lane-arithmetic model.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u1: WIDTH=1 registered; u8: WIDTH=8 registered; u16: WIDTH=16 registered; u0: WIDTH=1 combinational
    logic        a1 = 0, b1 = 0, v1 = 0;
    logic        s1, c1, o1;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        v8 = 0;
    logic [7:0]  s8, c8;
    logic        o8;
    logic [15:0] a16 = 0, b16 = 0;
    logic        v16 = 0;
    logic [15:0] s16, c16;
    logic        o16;
    logic        a0 = 0, b0 = 0, v0 = 0;
    logic        s0, c0, o0;

    half_adder #(.WIDTH(1),  .REG_OUT(1)) u1  (.clk(clk), .rst_n(rst_n), .a(a1),  .b(b1),  .in_valid(v1),  .sum(s1),  .carry(c1),  .out_valid(o1));
    half_adder #(.WIDTH(8),  .REG_OUT(1)) u8  (.clk(clk), .rst_n(rst_n), .a(a8),  .b(b8),  .in_valid(v8),  .sum(s8),  .carry(c8),  .out_valid(o8));
    half_adder #(.WIDTH(16), .REG_OUT(1)) u16 (.clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(v16), .sum(s16), .carry(c16), .out_valid(o16));
    half_adder #(.WIDTH(1),  .REG_OUT(0)) u0  (.clk(clk), .rst_n(rst_n), .a(a0),  .b(b0),  .in_valid(v0),  .sum(s0),  .carry(c0),  .out_valid(o0));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane-by-lane arithmetic: the two-bit total of a[i]+b[i] splits into carry and sum.
    function automatic logic [127:0] add_lanes(input logic [63:0] x, input logic [63:0] y, input int w);
        logic [63:0] s, c;
        int t;
        s = '0; c = '0;
        for (int i = 0; i < w; i++) begin
            t = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    // Model state for the registered instances and the combinational reset flag.
    logic [63:0] m1_s, m1_c, m8_s, m8_c, m16_s, m16_c;
    logic        m1_v, m8_v, m16_v, m0_flag;
    logic        ready = 1'b0;

    always @(posedge clk) begin
        logic [127:0] r;
        if (!rst_n) begin
            ready = 1'b1;
            {m1_s, m1_c, m8_s, m8_c, m16_s, m16_c} = '0;
            {m1_v, m8_v, m16_v} = '0;
        end else begin
            if (v1)  begin r = add_lanes(64'(a1),  64'(b1),  1);  {m1_c,  m1_s}  = r; end
            if (v8)  begin r = add_lanes(64'(a8),  64'(b8),  8);  {m8_c,  m8_s}  = r; end
            if (v16) begin r = add_lanes(64'(a16), 64'(b16), 16); {m16_c, m16_s} = r; end
            m1_v = v1; m8_v = v8; m16_v = v16;
        end
        m0_flag = !rst_n;
    end

    always @(negedge clk) begin
        logic [127:0] r;
        if (ready) begin
            chk("u1.sum",   64'(s1),  m1_s);
            chk("u1.carry", 64'(c1),  m1_c);
            chk("u1.valid", 64'(o1),  64'(m1_v));
            chk("u8.sum",   64'(s8),  m8_s);
            chk("u8.carry", 64'(c8),  m8_c);
            chk("u8.valid", 64'(o8),  64'(m8_v));
            chk("u16.sum",   64'(s16), m16_s);
            chk("u16.carry", 64'(c16), m16_c);
            chk("u16.valid", 64'(o16), 64'(m16_v));
            chk("u16.exclusive", 64'(s16 & c16), 64'd0);
            r = add_lanes(64'(a0), 64'(b0), 1);
            chk("u0.sum",   64'(s0), m0_flag ? 64'd0 : r[63:0]);
            chk("u0.carry", 64'(c0), m0_flag ? 64'd0 : r[127:64]);
            chk("u0.valid", 64'(o0), m0_flag ? 64'd0 : 64'(v0));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] exp_tab [4];
        logic [1:0] ab;
        exp_tab[0] = 2'b00; exp_tab[1] = 2'b01; exp_tab[2] = 2'b01; exp_tab[3] = 2'b10;

        tick; tick;
        chk("reset.u1", 64'({c1, s1, o1}), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0]; v1 = 1'b1;
            tick;
            chk("truth.u1", 64'({c1, s1}), 64'(exp_tab[i]));
            chk("truth.u1.valid", 64'(o1), 64'd1);
        end

        a1 = 1; b1 = 1; v1 = 1; tick;
        a1 = 0; b1 = 1; v1 = 0; tick;
        chk("hold.u1", 64'({c1, s1, o1}), 64'b100);

        a8 = 8'hF0; b8 = 8'hCC; v8 = 1; tick;
        chk("w8.sum",   64'(s8), 64'h3C);
        chk("w8.carry", 64'(c8), 64'hC0);
        chk("w8.valid", 64'(o8), 64'd1);
        v8 = 0;

        a0 = 1; b0 = 1; v0 = 1; #1;
        chk("comb.u0", 64'({c0, s0, o0}), 64'b101);

        rst_n = 1'b0; a1 = 1; b1 = 1; v1 = 1; tick;
        chk("midrst.u1", 64'({c1, s1, o1}), 64'd0);
        chk("midrst.u0", 64'({c0, s0, o0}), 64'd0);
        rst_n = 1'b1; a1 = 1; b1 = 0; v1 = 1; tick;
        chk("postrst.u1", 64'({c1, s1, o1}), 64'b011);
        chk("postrst.u0", 64'({c0, s0, o0}), 64'b101);

        for (int i = 0; i < 1000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'($urandom);
            a8  = 8'($urandom);  b8  = 8'($urandom);  v8  = 1'($urandom);
            a1  = 1'($urandom);  b1  = 1'($urandom);  v1  = 1'($urandom);
            a0  = 1'($urandom);  b0  = 1'($urandom);  v0  = 1'($urandom);
            tick;
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
